// File: rtl/cpu_readpath_pkg.sv
// cpu_readpath_pkg
// Shared definitions for the CPU load-return path: load size encodings and
// the per-load bookkeeping entry kept in the read-path circular buffer.
package cpu_readpath_pkg;

   // Load size encodings as issued by the pipeline (2'b11 behaves as word)
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // One in-flight load: issue attributes plus the formatted response data
   typedef struct packed {
      logic [4:0]  dest;
      logic [1:0]  size;
      logic        is_signed;
      logic [1:0]  offset;
      logic [31:0] data;
   } readpath_entry_t;

endpackage

// File: rtl/cpu_load_format.sv
// cpu_load_format
// Combinational alignment and sign/zero extension of a raw memory word.
// Ports:
//   rdata     in  32  raw response word
//   size      in  2   SIZE_BYTE / SIZE_HALF / SIZE_WORD (2'b11 = word)
//   is_signed in  1   1 = sign-extend, 0 = zero-extend
//   offset    in  2   address[1:0] of the load
//   result    out 32  aligned, extended result
import cpu_readpath_pkg::*;

module cpu_load_format (
   input  logic [31:0] rdata,
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [1:0]  offset,
   output logic [31:0] result
);

   logic [7:0]  byte_lane_s;
   logic [15:0] half_lane_s;

   // Lane selection, then extension according to size and signedness
   always_comb begin
      case (offset)
         2'b00:   byte_lane_s = rdata[7:0];
         2'b01:   byte_lane_s = rdata[15:8];
         2'b10:   byte_lane_s = rdata[23:16];
         2'b11:   byte_lane_s = rdata[31:24];
         default: byte_lane_s = rdata[7:0];
      endcase

      // offset[0] is ignored for halves: alignment is enforced upstream
      if (offset[1]) begin
         half_lane_s = rdata[31:16];
      end else begin
         half_lane_s = rdata[15:0];
      end

      case (size)
         SIZE_BYTE: result = {{24{is_signed & byte_lane_s[7]}}, byte_lane_s};
         SIZE_HALF: result = {{16{is_signed & half_lane_s[15]}}, half_lane_s};
         default:   result = rdata;
      endcase
   end

endmodule

// File: rtl/cpu_readpath.sv
// cpu_readpath
// Load-return path: records loads at issue, captures the in-order memory
// response, formats it, and presents results to the combine stage on the
// mem_valid/mem_ready handshake (producer side).
// Optional feature macro: READPATH_BYPASS_EN -- a response arriving while no
// completed result is waiting is presented combinationally in the same cycle.
// Ports:
//   clock, reset                       clock, synchronous active-high reset
//   p3_load_valid/dest/size/signed/offset  load issue attributes
//   p3_load_stall                      buffer full, upstream holds the load
//   dmem_rvalid, dmem_rdata            in-order memory response
//   mem_ready                          combine stage accepts result
//   mem_valid, mem_dest, mem_result    presented result (zeros when invalid)
//   rp_count                           entries in use
//   rp_error                           sticky: response with nothing outstanding
import cpu_readpath_pkg::*;

module cpu_readpath #(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   p3_load_valid,
   input  logic [4:0]             p3_load_dest,
   input  logic [1:0]             p3_load_size,
   input  logic                   p3_load_signed,
   input  logic [1:0]             p3_load_offset,
   output logic                   p3_load_stall,
   input  logic                   dmem_rvalid,
   input  logic [31:0]            dmem_rdata,
   input  logic                   mem_ready,
   output logic                   mem_valid,
   output logic [4:0]             mem_dest,
   output logic [31:0]            mem_result,
   output logic [$clog2(DEPTH):0] rp_count,
   output logic                   rp_error
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   readpath_entry_t entry_r [DEPTH];

   // Pointers carry an extra wrap bit so full and empty are distinguishable
   logic [PW-1:0] wr_ptr_r, rsp_ptr_r, rd_ptr_r;
   logic [PW-1:0] count_s, outstanding_s, completed_s;
   logic [AW-1:0] wr_idx_s, rsp_idx_s, rd_idx_s;
   logic          error_r;
   logic          issue_s, rsp_hit_s, orphan_s, retire_s;
   logic [31:0]   fmt_s;

   assign count_s       = wr_ptr_r - rd_ptr_r;
   assign outstanding_s = wr_ptr_r - rsp_ptr_r;
   assign completed_s   = rsp_ptr_r - rd_ptr_r;
   assign wr_idx_s      = wr_ptr_r[AW-1:0];
   assign rsp_idx_s     = rsp_ptr_r[AW-1:0];
   assign rd_idx_s      = rd_ptr_r[AW-1:0];

   // Stall comes from registered state only, so a same-cycle retire waits
   assign p3_load_stall = (count_s == PW'(DEPTH));
   assign issue_s       = p3_load_valid && !p3_load_stall;
   assign rsp_hit_s     = dmem_rvalid && (outstanding_s != {PW{1'b0}});
   assign orphan_s      = dmem_rvalid && (outstanding_s == {PW{1'b0}});
   assign retire_s      = mem_valid && mem_ready;
   assign rp_count      = count_s;
   assign rp_error      = error_r;

   cpu_load_format u_format (
      .rdata     (dmem_rdata),
      .size      (entry_r[rsp_idx_s].size),
      .is_signed (entry_r[rsp_idx_s].is_signed),
      .offset    (entry_r[rsp_idx_s].offset),
      .result    (fmt_s)
   );

   // Present the head entry; invalid cycles show zeros (a harmless x0 write)
   always_comb begin
      mem_valid  = 1'b0;
      mem_dest   = 5'd0;
      mem_result = 32'd0;
      if (completed_s != {PW{1'b0}}) begin
         mem_valid  = 1'b1;
         mem_dest   = entry_r[rd_idx_s].dest;
         mem_result = entry_r[rd_idx_s].data;
      end
`ifdef READPATH_BYPASS_EN
      // Nothing completed, so the responding entry is the head: forward it
      else if (rsp_hit_s) begin
         mem_valid  = 1'b1;
         mem_dest   = entry_r[rsp_idx_s].dest;
         mem_result = fmt_s;
      end
`endif
      else begin
         mem_valid  = 1'b0;
      end
   end

   // Pointer and sticky-error state; the three pointers move independently
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r  <= {PW{1'b0}};
         rsp_ptr_r <= {PW{1'b0}};
         rd_ptr_r  <= {PW{1'b0}};
         error_r   <= 1'b0;
      end else begin
         if (issue_s)   wr_ptr_r  <= wr_ptr_r + PW'(1);
         if (rsp_hit_s) rsp_ptr_r <= rsp_ptr_r + PW'(1);
         if (retire_s)  rd_ptr_r  <= rd_ptr_r + PW'(1);
         if (orphan_s)  error_r   <= 1'b1;
      end
   end

   // Entry storage; issue and response never target the same slot in a cycle
   // (a response needs outstanding > 0, which keeps rsp_ptr off wr_ptr unless
   // full, and a full buffer blocks issue). A bypassed-and-retired response
   // also writes its slot, which is dead once rd_ptr moves past it.
   always_ff @(posedge clock) begin
      if (issue_s) begin
         entry_r[wr_idx_s] <= '{dest:      p3_load_dest,
                                size:      p3_load_size,
                                is_signed: p3_load_signed,
                                offset:    p3_load_offset,
                                data:      32'd0};
      end
      if (rsp_hit_s) begin
         entry_r[rsp_idx_s].data <= fmt_s;
      end
   end

endmodule

// File: tb/tb_cpu_readpath.sv
// tb_cpu_readpath
// Self-checking bench for cpu_readpath (DEPTH=4): directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
// Honours READPATH_BYPASS_EN when the design is built with it.
module tb_cpu_readpath;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        p3_load_valid = 1'b0;
   logic [4:0]  p3_load_dest = 5'd0;
   logic [1:0]  p3_load_size = 2'd0;
   logic        p3_load_signed = 1'b0;
   logic [1:0]  p3_load_offset = 2'd0;
   logic        p3_load_stall;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        mem_ready = 1'b0;
   logic        mem_valid;
   logic [4:0]  mem_dest;
   logic [31:0] mem_result;
   logic [2:0]  rp_count;
   logic        rp_error;

   int checks = 0;
   int errors = 0;

   cpu_readpath #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .p3_load_valid(p3_load_valid), .p3_load_dest(p3_load_dest),
      .p3_load_size(p3_load_size), .p3_load_signed(p3_load_signed),
      .p3_load_offset(p3_load_offset), .p3_load_stall(p3_load_stall),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_dest(mem_dest),
      .mem_result(mem_result), .rp_count(rp_count), .rp_error(rp_error)
   );

   always #5 clock = ~clock;

   // Reference model: list of in-flight loads in issue order
   typedef struct {
      logic [4:0]  dest;
      logic [1:0]  size;
      bit          sgn;
      logic [1:0]  off;
      logic [31:0] data;
      bit          done;
   } mload_t;

   mload_t q[$];
   bit     merr = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Formatting rule expressed as plain arithmetic on the raw word
   function automatic logic [31:0] model_fmt(input logic [31:0] w, input logic [1:0] sz,
                                            input bit sg, input logic [1:0] off);
      int unsigned v;
      int unsigned bits;
      if (sz == 2'd0) begin
         v = (w >> (8 * int'(off))) & 32'hFF;
         bits = 8;
      end else if (sz == 2'd1) begin
         v = (off >= 2'd2) ? (w >> 16) : (w & 32'hFFFF);
         bits = 16;
      end else begin
         return w;
      end
      if (sg && (((v >> (bits - 1)) & 1) == 1)) v = v | (32'hFFFF_FFFF << bits);
      return v;
   endfunction

   function automatic int not_done();
      int n = 0;
      foreach (q[i]) if (!q[i].done) n++;
      return n;
   endfunction

   // One clock: drive inputs, compare every output at the falling edge,
   // advance the model, then idle the inputs just after the rising edge.
   task automatic do_cycle(input logic lv, input logic [4:0] ld, input logic [1:0] ls,
                           input logic lsg, input logic [1:0] lo,
                           input logic rv, input logic [31:0] rd, input logic rdy);
      bit          ev;
      logic [4:0]  ed;
      logic [31:0] er;
      bit          est;
      int          idx;
      p3_load_valid = lv; p3_load_dest = ld; p3_load_size = ls;
      p3_load_signed = lsg; p3_load_offset = lo;
      dmem_rvalid = rv; dmem_rdata = rd; mem_ready = rdy;
      @(negedge clock);
      est = (q.size() == DEPTH);
      ev = 1'b0; ed = 5'd0; er = 32'd0;
      if (q.size() > 0 && q[0].done) begin
         ev = 1'b1; ed = q[0].dest; er = q[0].data;
      end
`ifdef READPATH_BYPASS_EN
      else if (q.size() > 0 && rv) begin
         ev = 1'b1; ed = q[0].dest;
         er = model_fmt(rd, q[0].size, q[0].sgn, q[0].off);
      end
`endif
      check("stall", {31'd0, p3_load_stall}, {31'd0, est});
      check("count", {29'd0, rp_count}, q.size());
      check("valid", {31'd0, mem_valid}, {31'd0, ev});
      check("dest", {27'd0, mem_dest}, {27'd0, ed});
      check("result", mem_result, er);
      check("error", {31'd0, rp_error}, {31'd0, merr});
      // response targets the oldest load still waiting for data
      if (rv) begin
         idx = -1;
         foreach (q[i]) if (idx < 0 && !q[i].done) idx = i;
         if (idx >= 0) begin
            q[idx].data = model_fmt(rd, q[idx].size, q[idx].sgn, q[idx].off);
            q[idx].done = 1'b1;
         end else begin
            merr = 1'b1;
         end
      end
      if (lv && !est) q.push_back('{ld, ls, lsg, lo, 32'd0, 1'b0});
      if (ev && rdy) void'(q.pop_front());
      @(posedge clock);
      #1;
      p3_load_valid = 1'b0; dmem_rvalid = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic issue(input logic [4:0] d, input logic [1:0] s, input logic sg, input logic [1:0] o);
      do_cycle(1'b1, d, s, sg, o, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic respond(input logic [31:0] w, input logic rdy);
      do_cycle(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, w, rdy);
   endtask

   task automatic retire();
      do_cycle(1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      p3_load_valid = 1'b0; dmem_rvalid = 1'b0; mem_ready = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      q.delete();
      merr = 1'b0;
      check("rst_valid", {31'd0, mem_valid}, 32'd0);
      check("rst_dest", {27'd0, mem_dest}, 32'd0);
      check("rst_result", mem_result, 32'd0);
      check("rst_count", {29'd0, rp_count}, 32'd0);
      check("rst_stall", {31'd0, p3_load_stall}, 32'd0);
      check("rst_error", {31'd0, rp_error}, 32'd0);
   endtask

   initial begin
      @(posedge clock);
      #1;
      do_reset();

      // signed byte from lane 1
      issue(5'd5, 2'b00, 1'b1, 2'd1);
      respond(32'h0000_8000, 1'b0);
      check("byte_dest", {27'd0, mem_dest}, 32'd5);
      check("byte_result", mem_result, 32'hFFFF_FF80);
      retire();
      check("byte_count", {29'd0, rp_count}, 32'd0);

      // unsigned upper half, then a word
      issue(5'd6, 2'b01, 1'b0, 2'd2);
      issue(5'd7, 2'b10, 1'b1, 2'd0);
      respond(32'hBEEF_1234, 1'b0);
      respond(32'hDEAD_BEEF, 1'b0);
      check("half_result", mem_result, 32'h0000_BEEF);
      retire();
      check("word_result", mem_result, 32'hDEAD_BEEF);
      retire();

      // fill to DEPTH, fifth issue ignored, stall releases a cycle after retire
      for (int i = 0; i < DEPTH; i++) issue(5'(10 + i), 2'b10, 1'b0, 2'd0);
      check("full_stall", {31'd0, p3_load_stall}, 32'd1);
      issue(5'd20, 2'b10, 1'b0, 2'd0);
      check("full_count", {29'd0, rp_count}, 32'd4);
      respond(32'h1111_0000, 1'b0);
      retire();
      check("stall_release", {31'd0, p3_load_stall}, 32'd0);

      // three responses held back, then retired in order
      for (int i = 0; i < 3; i++) respond(32'h2222_0000 + 32'(i), 1'b0);
      check("held_valid", {31'd0, mem_valid}, 32'd1);
      check("held_dest", {27'd0, mem_dest}, 32'd11);
      for (int i = 0; i < 3; i++) retire();
      check("drained", {29'd0, rp_count}, 32'd0);

      // orphan response sets sticky error
      respond(32'hCAFE_0000, 1'b1);
      check("err_set", {31'd0, rp_error}, 32'd1);
      retire();
      retire();
      check("err_sticky", {31'd0, rp_error}, 32'd1);

      // reset with two loads in flight
      issue(5'd3, 2'b10, 1'b0, 2'd0);
      issue(5'd4, 2'b00, 1'b0, 2'd3);
      respond(32'h0102_0304, 1'b0);
      do_reset();

`ifdef READPATH_BYPASS_EN
      issue(5'd9, 2'b10, 1'b0, 2'd0);
      respond(32'h1234_5678, 1'b1);
      check("bypass_count", {29'd0, rp_count}, 32'd0);
`endif

      // randomized traffic; responses only while the model has loads waiting
      for (int c = 0; c < 600; c++) begin
         logic rv;
         rv = (not_done() > 0) && ($urandom_range(0, 1) == 1);
         do_cycle(($urandom_range(0, 2) != 0), 5'($urandom), 2'($urandom), 1'($urandom),
                  2'($urandom), rv, $urandom, ($urandom_range(0, 2) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
